// File: rtl/fifo_event_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_event_scheduler
//
// Purpose:
//   Shares the write port of the key-event FIFO among N_REQ event sources using
//   round-robin arbitration. Also sequences host reads and clears of that FIFO.
//   The FIFO has no full flag, so this block keeps a shadow copy of its
//   occupancy. A write is never issued into a full FIFO.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req             level request, one bit per source
//   ev_data         event of source i in [i*EV_WIDTH +: EV_WIDTH]
//   ack             1-cycle pulse: the event of source i was accepted
//   host_rd         1-cycle host read request
//   host_clr        1-cycle host clear request (highest priority)
//   rd_done         1-cycle pulse: the FIFO output now holds the read event
//   rd_empty        1-cycle pulse: the read was refused because the FIFO is empty
//   fifo_in         data to the FIFO, held stable for the whole write sequence
//   fifo_wr/fifo_rd write/read strobes to the FIFO (the FIFO edge-detects them)
//   fifo_clr        1-cycle clear strobe to the FIFO
//   level           shadow occupancy, 0..CAPACITY
//   full, empty     decoded from level
//   blocked         sticky flag: a request was waiting while the FIFO was full
// -----------------------------------------------------------------------------
module fifo_event_scheduler #(
  parameter int N_REQ     = 4,
  parameter int EV_WIDTH  = 8,
  parameter int CAP_WIDTH = 3,
  parameter int CAPACITY  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*EV_WIDTH-1:0] ev_data,
  output logic [N_REQ-1:0]          ack,
  input  logic                      host_rd,
  input  logic                      host_clr,
  output logic                      rd_done,
  output logic                      rd_empty,
  output logic [EV_WIDTH-1:0]       fifo_in,
  output logic                      fifo_wr,
  output logic                      fifo_rd,
  output logic                      fifo_clr,
  output logic [CAP_WIDTH:0]        level,
  output logic                      full,
  output logic                      empty,
  output logic                      blocked
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CAP_WIDTH:0] CAP_L = CAPACITY[CAP_WIDTH:0];

  typedef enum logic [2:0] {W_IDLE, W_HI, W_HOLD, W_LO1, W_LO2} wr_state_t;
  typedef enum logic [2:0] {R_IDLE, R_HI, R_HOLD, R_LO1, R_LO2} rd_state_t;

  wr_state_t              wr_state_q, wr_state_d;
  rd_state_t              rd_state_q, rd_state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [CAP_WIDTH:0]     level_q, level_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic [EV_WIDTH-1:0]    fifo_in_q, fifo_in_d;
  logic                   fifo_wr_q, fifo_wr_d;
  logic                   fifo_rd_q, fifo_rd_d;
  logic                   fifo_clr_q, fifo_clr_d;
  logic                   rd_done_q, rd_done_d;
  logic                   rd_empty_q, rd_empty_d;
  logic                   blocked_q, blocked_d;

  // Per-source view of the packed event bus
  logic [EV_WIDTH-1:0] ev_arr [N_REQ];
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ev
    assign ev_arr[gi] = ev_data[gi*EV_WIDTH +: EV_WIDTH];
  end

  // Round-robin pick: the lowest requester at or above the pointer wins.
  // If there is none, the lowest requester overall wins (wrap-around).
  logic [N_REQ-1:0] mask_hi, req_hi;
  logic [PTR_W-1:0] idx_hi, idx_lo, grant_idx;

  always_comb begin
    mask_hi = '0;
    idx_hi  = '0;
    idx_lo  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      mask_hi[j] = (j >= int'(ptr_q));
    end
    req_hi = req & mask_hi;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_hi[j]) idx_hi = j[PTR_W-1:0];
      if (req[j])    idx_lo = j[PTR_W-1:0];
    end
    grant_idx = (|req_hi) ? idx_hi : idx_lo;
  end

  // full and empty come from the registered level. A read accepted in the same
  // cycle therefore sees the occupancy from before any grant in that cycle.
  assign full  = (level_q == CAP_L);
  assign empty = (level_q == '0);

  logic grant, rd_accept;
  assign grant     = (wr_state_q == W_IDLE) && (|req) && !full;
  assign rd_accept = (rd_state_q == R_IDLE) && host_rd && !empty;

  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    ptr_d      = ptr_q;
    level_d    = level_q;
    ack_d      = '0;
    fifo_in_d  = fifo_in_q;
    fifo_clr_d = 1'b0;
    rd_done_d  = 1'b0;
    rd_empty_d = 1'b0;
    blocked_d  = blocked_q;

    if (host_clr) begin
      // The clear cuts short any write in flight. That event is dropped even
      // though its ack has already gone out.
      wr_state_d = W_IDLE;
      rd_state_d = R_IDLE;
      level_d    = '0;
      blocked_d  = 1'b0;
      fifo_clr_d = 1'b1;
    end else begin
      unique case (wr_state_q)
        W_IDLE: begin
          if (grant) begin
            wr_state_d = W_HI;
            ack_d      = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
            fifo_in_d  = ev_arr[grant_idx];
            ptr_d      = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          end
          if ((|req) && full) blocked_d = 1'b1;
        end
        W_HI:    wr_state_d = W_HOLD;
        W_HOLD:  wr_state_d = W_LO1;
        W_LO1:   wr_state_d = W_LO2;
        W_LO2:   wr_state_d = W_IDLE;
        default: wr_state_d = W_IDLE;
      endcase

      unique case (rd_state_q)
        R_IDLE: begin
          if (rd_accept) rd_state_d = R_HI;
          if (host_rd && empty) rd_empty_d = 1'b1;
        end
        R_HI:    rd_state_d = R_HOLD;
        R_HOLD:  rd_state_d = R_LO1;
        R_LO1: begin
          rd_state_d = R_LO2;
          rd_done_d  = 1'b1;
        end
        R_LO2:   rd_state_d = R_IDLE;
        default: rd_state_d = R_IDLE;
      endcase

      // A grant and a read in the same cycle cancel out
      if (grant && !rd_accept) begin
        level_d = level_q + 1'b1;
      end else if (!grant && rd_accept) begin
        level_d = level_q - 1'b1;
      end
    end

    // The strobes are registered from the next state, so the FIFO's edge
    // detectors see clean, glitch-free levels
    fifo_wr_d = (wr_state_d == W_HI) || (wr_state_d == W_HOLD);
    fifo_rd_d = (rd_state_d == R_HI) || (rd_state_d == R_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      ptr_q      <= '0;
      level_q    <= '0;
      ack_q      <= '0;
      fifo_in_q  <= '0;
      fifo_wr_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_clr_q <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_empty_q <= 1'b0;
      blocked_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      ptr_q      <= ptr_d;
      level_q    <= level_d;
      ack_q      <= ack_d;
      fifo_in_q  <= fifo_in_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_clr_q <= fifo_clr_d;
      rd_done_q  <= rd_done_d;
      rd_empty_q <= rd_empty_d;
      blocked_q  <= blocked_d;
    end
  end

  assign ack      = ack_q;
  assign fifo_in  = fifo_in_q;
  assign fifo_wr  = fifo_wr_q;
  assign fifo_rd  = fifo_rd_q;
  assign fifo_clr = fifo_clr_q;
  assign rd_done  = rd_done_q;
  assign rd_empty = rd_empty_q;
  assign level    = level_q;
  assign blocked  = blocked_q;

endmodule

// File: tb/tb_fifo_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fifo_event_scheduler
//
// Purpose:
//   Directed test of fifo_event_scheduler. Inputs are driven on the falling
//   edge and outputs are checked on the falling edge. Every expected value is
//   worked out by hand from the cycle-by-cycle behaviour of the write and read
//   sequences.
// -----------------------------------------------------------------------------
module tb_fifo_event_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] ev_data;
  logic [3:0]  ack;
  logic        host_rd;
  logic        host_clr;
  logic        rd_done;
  logic        rd_empty;
  logic [7:0]  fifo_in;
  logic        fifo_wr;
  logic        fifo_rd;
  logic        fifo_clr;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic        blocked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_event_scheduler #(
    .N_REQ(4), .EV_WIDTH(8), .CAP_WIDTH(3), .CAPACITY(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ev_data(ev_data), .ack(ack),
    .host_rd(host_rd), .host_clr(host_clr), .rd_done(rd_done),
    .rd_empty(rd_empty), .fifo_in(fifo_in), .fifo_wr(fifo_wr),
    .fifo_rd(fifo_rd), .fifo_clr(fifo_clr), .level(level), .full(full),
    .empty(empty), .blocked(blocked)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] exp_ack;
    logic [7:0] exp_ev;
    int         src;

    rst = 1'b1; req = '0; ev_data = '0; host_rd = 1'b0; host_clr = 1'b0;
    step(); step();

    // Reset state
    chk("rst_ack", ack, 0);          chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_fifo_rd", fifo_rd, 0);  chk("rst_fifo_clr", fifo_clr, 0);
    chk("rst_rd_done", rd_done, 0);  chk("rst_rd_empty", rd_empty, 0);
    chk("rst_level", level, 0);      chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);        chk("rst_blocked", blocked, 0);
    chk("rst_fifo_in", fifo_in, 0);

    // 1: a single event from source 0
    rst = 1'b0; req = 4'b0001; ev_data = 32'h0000_00A5;
    step();
    chk("t1_ack", ack, 4'b0001); chk("t1_wr_hi", fifo_wr, 1);
    chk("t1_fifo_in", fifo_in, 8'hA5); chk("t1_level", level, 1);
    chk("t1_empty", empty, 0);
    req = 4'b0000;
    step(); chk("t1_ack_off", ack, 0); chk("t1_wr_hold", fifo_wr, 1);
    step(); chk("t1_wr_lo", fifo_wr, 0);
    step(); step();
    chk("t1_level_end", level, 1); chk("t1_in_stable", fifo_in, 8'hA5);

    // 2: after reset the pointer is 0; all four sources request
    rst = 1'b1;
    step();
    rst = 1'b0; req = 4'b1111; ev_data = 32'hD3C2_B1A0;
    chk("t2_level_rst", level, 0);
    for (int e = 0; e < 4; e++) begin
      step();
      exp_ack = 4'b0001 << e;
      exp_ev  = ev_data[e*8 +: 8];
      chk("t2_ack", ack, exp_ack);
      chk("t2_fifo_in", fifo_in, exp_ev);
      chk("t2_level", level, e + 1);
      for (int k = 0; k < 4; k++) begin
        step(); chk("t2_gap", ack, 0);
      end
    end

    // 3: fill to capacity from source 0, then source 2 is held off
    req = 4'b0001;
    for (int e = 0; e < 4; e++) begin
      step();
      chk("t3_ack0", ack, 4'b0001);
      chk("t3_level", level, 5 + e);
      step(); step(); step(); step();
    end
    req = 4'b0100;
    chk("t3_full", full, 1);
    step(); chk("t3_blocked", blocked, 1); chk("t3_no_ack", ack, 0);
    step(); chk("t3_no_ack2", ack, 0); chk("t3_level8", level, 8);
    host_rd = 1'b1;
    step(); chk("t3_rd_level", level, 7); chk("t3_fifo_rd", fifo_rd, 1);
    chk("t3_ack_wait", ack, 0); chk("t3_not_full", full, 0);
    host_rd = 1'b0;
    step(); chk("t3_ack2", ack, 4'b0100); chk("t3_level_re", level, 8);
    chk("t3_fifo_in", fifo_in, 8'hC2); chk("t3_rd_hold", fifo_rd, 1);
    req = 4'b0000;
    step(); chk("t3_rd_lo1", rd_done, 0); chk("t3_rd_low", fifo_rd, 0);
    step(); chk("t3_rd_done", rd_done, 1);
    step(); chk("t3_rd_done_off", rd_done, 0);

    // Clear while full and blocked
    host_clr = 1'b1;
    step(); chk("clr_pulse", fifo_clr, 1); chk("clr_level", level, 0);
    chk("clr_blocked", blocked, 0); chk("clr_empty", empty, 1);
    chk("clr_ack", ack, 0);
    host_clr = 1'b0;
    step(); chk("clr_off", fifo_clr, 0);

    // 6: clear during the W_HOLD phase of a write (pointer 3 wraps to source 1)
    req = 4'b0010;
    step(); chk("t6_ack", ack, 4'b0010); chk("t6_wr", fifo_wr, 1);
    chk("t6_fifo_in", fifo_in, 8'hB1); chk("t6_level", level, 1);
    req = 4'b0000;
    step(); chk("t6_wr_hold", fifo_wr, 1);
    host_clr = 1'b1;
    step(); chk("t6_clr", fifo_clr, 1); chk("t6_wr_drop", fifo_wr, 0);
    chk("t6_level", level, 0); chk("t6_ack_none", ack, 0);
    chk("t6_blocked", blocked, 0);
    host_clr = 1'b0;
    step(); chk("t6_clr_off", fifo_clr, 0); chk("t6_wr_idle", fifo_wr, 0);

    // 4: read from an empty FIFO
    host_rd = 1'b1;
    step(); chk("t4_rd_empty", rd_empty, 1); chk("t4_fifo_rd", fifo_rd, 0);
    chk("t4_level", level, 0);
    host_rd = 1'b0;
    step(); chk("t4_rd_empty_off", rd_empty, 0); chk("t4_fifo_rd2", fifo_rd, 0);

    // 5: the pointer survived the clear (it is 2); fill to 3, then grant and read together
    req = 4'b1111;
    for (int e = 0; e < 3; e++) begin
      step();
      src     = (e + 2) % 4;
      exp_ack = 4'b0001 << src;
      exp_ev  = ev_data[src*8 +: 8];
      chk("t5_ack", ack, exp_ack);
      chk("t5_fifo_in", fifo_in, exp_ev);
      step(); step(); step(); step();
    end
    chk("t5_level3", level, 3);
    host_rd = 1'b1;
    step(); chk("t5_ack_src1", ack, 4'b0010); chk("t5_level_same", level, 3);
    chk("t5_fifo_rd", fifo_rd, 1); chk("t5_fifo_wr", fifo_wr, 1);
    host_rd = 1'b0; req = 4'b0000;
    step(); chk("t5_rd_hold", fifo_rd, 1); chk("t5_done_early", rd_done, 0);
    step(); chk("t5_rd_lo", fifo_rd, 0); chk("t5_done_early2", rd_done, 0);
    step(); chk("t5_rd_done", rd_done, 1); chk("t5_level_end", level, 3);
    step(); chk("t5_rd_done_off", rd_done, 0);

    // Reset in the middle of a write
    req = 4'b0001;
    step(); chk("mr_ack", ack, 4'b0001); chk("mr_wr", fifo_wr, 1);
    chk("mr_level", level, 4);
    rst = 1'b1; req = 4'b0000;
    step(); chk("mr_wr_drop", fifo_wr, 0); chk("mr_ack_off", ack, 0);
    chk("mr_level0", level, 0); chk("mr_empty", empty, 1);
    chk("mr_fifo_in", fifo_in, 0);
    rst = 1'b0;
    step(); chk("mr_wr_idle", fifo_wr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
